// File: rtl/ds_pkg.sv
// Shared widths, constants and the saturating adder for the second-order
// delta-sigma modulator and its noise-shaping core.
package ds_pkg;
    localparam int WIDTH    = 20;
    localparam int LOG2_OSR = 8;
    localparam int IW       = WIDTH + 4;
    localparam int OSR      = 1 << LOG2_OSR;

    localparam logic        [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [IW-1:0]    INT_MAX  = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0]    INT_MIN  = {1'b1, {(IW-1){1'b0}}};

    typedef struct packed {
        logic                 clamped;
        logic signed [IW-1:0] value;
    } sat_t;

    // Three integrator-sized operands are summed with two guard bits so the
    // raw sum can never wrap before it is clamped.
    function automatic sat_t satAdd(input logic signed [IW-1:0] a,
                                    input logic signed [IW-1:0] b,
                                    input logic signed [IW-1:0] c);
        logic signed [IW+1:0] sum;
        sat_t                 r;
        sum       = (IW+2)'(a) + (IW+2)'(b) + (IW+2)'(c);
        r.clamped = 1'b1;
        r.value   = INT_MAX;
        if (sum > (IW+2)'(INT_MAX)) begin
            r.value = INT_MAX;
        end else if (sum < (IW+2)'(INT_MIN)) begin
            r.value = INT_MIN;
        end else begin
            r.clamped = 1'b0;
            r.value   = sum[IW-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/ds_mod2_core.sv
// Second-order noise shaper: two saturating integrators and a 1-bit quantizer
// whose registered decision is fed back as +/- midscale.
module ds_mod2_core
    import ds_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] u,
    output logic                    out,
    output logic                    sat
);
    localparam logic signed [IW-1:0] VPOS = IW'(MIDSCALE);
    localparam logic signed [IW-1:0] VNEG = -VPOS;

    logic signed [IW-1:0] i1_q, i1_d;
    logic signed [IW-1:0] i2_q, i2_d;
    logic signed [IW-1:0] negV;
    logic                 out_q, out_d;
    logic                 sat_q, sat_d;
    sat_t                 s1, s2;

    // The second integrator consumes the first one's new value, which gives
    // the classic (1 - z^-1)^2 noise transfer with a one-sample signal delay.
    always_comb begin
        negV  = out_q ? VNEG : VPOS;
        s1    = satAdd(i1_q, IW'(u), negV);
        s2    = satAdd(i2_q, s1.value, negV);
        i1_d  = i1_q;
        i2_d  = i2_q;
        out_d = out_q;
        sat_d = sat_q;
        if (en) begin
            i1_d  = s1.value;
            i2_d  = s2.value;
            out_d = ~s2.value[IW-1];
            sat_d = sat_q | s1.clamped | s2.clamped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q  <= '0;
            i2_q  <= '0;
            out_q <= 1'b0;
            sat_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            out_q <= out_d;
            sat_q <= sat_d;
        end
    end

    assign out = out_q;
    assign sat = sat_q;
endmodule

// File: rtl/ds_modulator.sv
// Delta-sigma DAC front end: one-deep sample buffer, OSR phase counter and a
// linear interpolator feeding the second-order noise-shaping core.
module ds_modulator
    import ds_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             underrun,
    output logic             sat
);
    localparam int AW = WIDTH + LOG2_OSR;

    logic [LOG2_OSR-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0]       next_q, next_d;
    logic                   next_full_q, next_full_d;
    logic [WIDTH-1:0]       cur_q, cur_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic signed [WIDTH:0]  delta_q, delta_d;
    logic                   underrun_q, underrun_d;
    logic                   transfer;
    logic                   boundary;
    logic [WIDTH-1:0]       x;
    logic signed [WIDTH-1:0] u;

    assign in_ready = ~next_full_q;
    assign transfer = in_valid & ~next_full_q;
    assign boundary = en & (&phase_q);

    // At each boundary the accumulator restarts from the outgoing sample and
    // then walks toward the new one by delta per cycle, so x lands on the new
    // sample exactly OSR cycles later. An empty buffer repeats the last value.
    always_comb begin
        phase_d     = phase_q;
        next_d      = next_q;
        next_full_d = next_full_q;
        cur_d       = cur_q;
        acc_d       = acc_q;
        delta_d     = delta_q;
        underrun_d  = underrun_q;
        if (en) begin
            phase_d = phase_q + LOG2_OSR'(1);
        end
        if (boundary) begin
            acc_d = {cur_q, {LOG2_OSR{1'b0}}};
            if (next_full_q) begin
                cur_d       = next_q;
                delta_d     = $signed({1'b0, next_q}) - $signed({1'b0, cur_q});
                next_full_d = 1'b0;
            end else begin
                delta_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (en) begin
            acc_d = acc_q + AW'(delta_q);
        end
        if (transfer) begin
            next_d      = in_data;
            next_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            next_q      <= '0;
            next_full_q <= 1'b0;
            cur_q       <= MIDSCALE;
            acc_q       <= {MIDSCALE, {LOG2_OSR{1'b0}}};
            delta_q     <= '0;
            underrun_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            next_q      <= next_d;
            next_full_q <= next_full_d;
            cur_q       <= cur_d;
            acc_q       <= acc_d;
            delta_q     <= delta_d;
            underrun_q  <= underrun_d;
        end
    end

    assign x = acc_q[AW-1:LOG2_OSR];
    assign u = $signed({~x[WIDTH-1], x[WIDTH-2:0]});

    ds_mod2_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .u     (u),
        .out   (out),
        .sat   (sat)
    );

    assign underrun = underrun_q;
endmodule

// File: tb/tb_ds_modulator.sv
// Scoreboard bench for ds_modulator: accepted samples are queued as they are
// driven and retired at each sample boundary, predicting x, in_ready and underrun.
module tb_ds_modulator;
    import ds_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] inData;
    logic             inValid;
    logic             inReady;
    logic             outBit;
    logic             underrun;
    logic             sat;

    logic [WIDTH-1:0]    xProbe;
    logic [LOG2_OSR-1:0] phaseProbe;

    int checkCount = 0;
    int errorCount = 0;

    logic [WIDTH-1:0] sbQueue[$];
    int               phaseM;
    logic [WIDTH-1:0] curM;
    logic [WIDTH-1:0] prevM;
    logic             underrunM;
    bit               lastXfer;
    bit               checkXfer;
    int               xferInPeriod;
    int               xferTotal;
    bit               counting;
    int               onesCount;
    int               rampOnes;
    int               rampCycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ds_modulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (inData),
        .in_valid (inValid),
        .in_ready (inReady),
        .out      (outBit),
        .underrun (underrun),
        .sat      (sat)
    );

    assign xProbe     = dut.acc_q[WIDTH+LOG2_OSR-1:LOG2_OSR];
    assign phaseProbe = dut.phase_q;

    // Interpolated value the ramp should show at the model's current phase.
    function automatic logic [WIDTH-1:0] expectedX();
        longint d;
        longint t;
        d = longint'(curM) - longint'(prevM);
        t = (d * longint'(phaseM)) >>> LOG2_OSR;
        return WIDTH'(longint'(prevM) + t);
    endfunction

    task automatic checkOutput(input string tag, input longint observed,
                               input longint expected, input longint tol = 0);
        longint diff;
        checkCount++;
        diff = observed - expected;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, observed, observed, expected, expected, tol);
        end
    endtask

    task automatic modelReset();
        sbQueue.delete();
        phaseM       = 0;
        curM         = MIDSCALE;
        prevM        = MIDSCALE;
        underrunM    = 1'b0;
        xferInPeriod = 0;
        xferTotal    = 0;
    endtask

    // Reset is asserted between clock edges so the async path is what clears state.
    task automatic applyReset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        inValid = 1'b0;
        en      = 1'b0;
        #1;
        checkOutput("rst_out", outBit, 0);
        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_sat", sat, 0);
        checkOutput("rst_phase", phaseProbe, 0);
        checkOutput("rst_x", xProbe, MIDSCALE);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                                 input logic enable);
        bit readyM;
        inValid = valid;
        inData  = data;
        en      = enable;
        @(posedge clk);
        readyM   = (sbQueue.size() == 0);
        lastXfer = valid && readyM;
        if (enable) begin
            if (phaseM == OSR - 1) begin
                prevM = curM;
                if (sbQueue.size() != 0) curM = sbQueue.pop_front();
                else underrunM = 1'b1;
                if (checkXfer) checkOutput("xfer_per_osr", xferInPeriod, 1);
                xferInPeriod = 0;
            end
            phaseM = (phaseM + 1) % OSR;
        end
        if (lastXfer) begin
            sbQueue.push_back(data);
            xferInPeriod++;
            xferTotal++;
        end
        @(negedge clk);
        checkOutput("in_ready", inReady, (sbQueue.size() == 0) ? 1 : 0);
        checkOutput("underrun", underrun, underrunM);
        if (phaseM % 32 == 0) begin
            checkOutput("x", xProbe, expectedX());
            checkOutput("phase", phaseProbe, phaseM);
        end
        if (enable && prevM == 20'h80000 && curM == 20'hC0000) begin
            rampOnes += int'(outBit);
            rampCycles++;
            if (phaseM == 128) checkOutput("ramp_x128", xProbe, 20'hA0000);
        end
        if (counting && enable) onesCount += int'(outBit);
    endtask

    task automatic runSteady(input logic [WIDTH-1:0] data, input int settle,
                             input int window, input int expOnes, input int tol,
                             input string tag);
        for (int i = 0; i < settle; i++) applyStimulus(1'b1, data, 1'b1);
        onesCount = 0;
        counting  = 1'b1;
        for (int i = 0; i < window; i++) applyStimulus(1'b1, data, 1'b1);
        counting = 1'b0;
        checkOutput(tag, onesCount, expOnes, tol);
    endtask

    initial begin
        int               toggles;
        logic             lastOut;
        logic [WIDTH-1:0] seqData;

        rst_n     = 1'b1;
        en        = 1'b0;
        inValid   = 1'b0;
        inData    = '0;
        checkXfer = 1'b0;
        counting  = 1'b0;
        onesCount = 0;
        rampOnes  = 0;
        rampCycles = 0;
        modelReset();

        // Midscale: half density, no flags.
        applyReset();
        runSteady(20'h80000, 0, 4096, 2048, 4, "dens_mid");
        checkOutput("sat_mid", sat, 0);

        // Three-quarter scale, then a 100-cycle freeze and resume.
        applyReset();
        runSteady(20'hC0000, 1024, 4096, 3072, 4, "dens_c0000");
        checkOutput("sat_c0000", sat, 0);
        toggles = 0;
        lastOut = outBit;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 20'hC0000, 1'b0);
            if (outBit !== lastOut) toggles++;
            lastOut = outBit;
        end
        checkOutput("freeze_toggles", toggles, 0);
        checkOutput("freeze_phase", phaseProbe, phaseM);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 20'hC0000, 1'b1);

        // 0.2 full-scale density.
        applyReset();
        runSteady(20'h33333, 1024, 4096, 819, 4, "dens_33333");
        checkOutput("sat_33333", sat, 0);

        // Ramp from 0x80000 to 0xC0000 across one sample period.
        applyReset();
        rampOnes   = 0;
        rampCycles = 0;
        applyStimulus(1'b1, 20'h80000, 1'b1);
        for (int i = 0; i < 4 * OSR; i++) applyStimulus(1'b1, 20'hC0000, 1'b1);
        checkOutput("ramp_cycles", rampCycles, OSR);
        checkOutput("ramp_ones", rampOnes, 160, 6);

        // Single sample, then starvation and a late sample in the boundary cycle.
        applyReset();
        applyStimulus(1'b1, 20'h90000, 1'b1);
        for (int i = 0; i < 510; i++) applyStimulus(1'b0, 20'h0, 1'b1);
        checkOutput("underrun_pre", underrun, 0);
        applyStimulus(1'b1, 20'hB0000, 1'b1);
        checkOutput("underrun_set", underrun, 1);
        for (int i = 0; i < 128; i++) applyStimulus(1'b0, 20'h0, 1'b1);
        checkOutput("hold_x", xProbe, 20'h90000);
        for (int i = 0; i < 472; i++) applyStimulus(1'b0, 20'h0, 1'b1);
        checkOutput("late_sample_x", xProbe, 20'hB0000);

        // Back-pressure with a sequence of distinct samples.
        applyReset();
        checkXfer = 1'b1;
        seqData   = 20'h70000;
        for (int i = 0; i < 8 * OSR + 10; i++) begin
            applyStimulus(1'b1, seqData, 1'b1);
            if (lastXfer) seqData = seqData + 20'h02000;
        end
        checkXfer = 1'b0;
        checkOutput("xfer_total", xferTotal, 9);
        checkOutput("underrun_bp", underrun, 0);

        // Full-scale overload: clamps, no wrap, then async reset mid-sample.
        applyReset();
        runSteady(20'hFFFFF, 1024, 1024, 1024, 51, "dens_full");
        checkOutput("sat_full", sat, 1);
        for (int i = 0; i < 77; i++) applyStimulus(1'b1, 20'hFFFFF, 1'b1);
        checkOutput("out_full", outBit, 1);
        applyReset();
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 20'h80000, 1'b1);
        checkOutput("sat_after_rst", sat, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
